traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Parametrised successor to the fixed-timing traffic-light controller: two-way (main/side) junction with pedestrian phase.
//  Internal tick prescaler replaces the separate clock-divider module, so all logic runs on one clock.
//  Phase durations are parameters. Adds side-sensor-driven green shortening/extension and a flashing-red maintenance mode.
//  Every exit from flash or reset passes through an all-red clearance.
//  Lamp encoding is unchanged: 3'b100=green, 3'b010=yellow, 3'b001=red, 3'b000=dark.
// PARAMETERS
//  TICK_DIV     50_000_000  fast_clock cycles per phase tick (>=2)
//  TW           5           phase timer width; every duration must be 1..2**TW-1
//  MAIN_GRN     9           main green ticks, no pending request
//  MAIN_GRN_SH  6           main green ticks when walk or side request pending
//  SIDE_GRN     6           side green ticks, sensor low
//  SIDE_GRN_LG  9           side green ticks, sensor held high
//  YEL          2           yellow ticks (both roads)
//  WALK_T       3           pedestrian ticks (main and side red)
//  ALLRED_T     2           all-red clearance ticks
// PORTS
//  fast_clock   in   1  system clock
//  reset        in   1  asynchronous, active-high
//  walk_button  in   1  pedestrian request, any-width pulse
//  side_sensor  in   1  side-road vehicle present (level, async)
//  flash_mode   in   1  maintenance request (level, async)
//  main         out  3  main-street lamps
//  side         out  3  side-street lamps
//  walk_light   out  1  pedestrian walk lamp
//  led_clock    out  1  toggles once per tick (debug LED)
//  walk_pending out  1  walk request latched, not yet served
// BEHAVIOUR
//  Reset (async, immediate, including mid-phase):
//   - state=ALL_RED, timer=0, prescaler=0, walk_req=0, led_clock=0.
//   - main=001, side=001, walk_light=0.
//  Inputs: side_sensor and flash_mode pass through 2-flop synchronisers before use. walk_button is sampled directly.
//  Tick:
//   - Prescaler counts 0..TICK_DIV-1 and wraps.
//   - tick=1 for exactly one cycle when prescaler==TICK_DIV-1.
//   - led_clock toggles on that edge.
//  Timer:
//   - Advances only on tick.
//   - A state with duration D exits on the tick where timer==D-1. The exit sets timer=0.
//   - The duration is evaluated at that tick.
//  State transitions (taken only on tick):
//   - ALL_RED: -> MAIN_GRN.
//   - MAIN_GRN: D = MAIN_GRN_SH if walk_req or sensor_sync, else MAIN_GRN. -> MAIN_YEL.
//     If a request appears after timer>=MAIN_GRN_SH-1, exit on the next tick.
//   - MAIN_YEL: D=YEL. -> WALK if walk_req, else SIDE_GRN.
//   - WALK: D=WALK_T. -> SIDE_GRN. Clears walk_req on exit.
//   - SIDE_GRN: D = SIDE_GRN_LG if sensor_sync, else SIDE_GRN. Same late-change rule as MAIN_GRN. -> SIDE_YEL.
//   - SIDE_YEL: D=YEL. -> MAIN_GRN.
//   - FLASH: main=side=001 on even ticks, 000 on odd ticks; walk_light=0. Remains while flash_sync=1.
//   - flash_sync=1 seen at any tick, from any state: -> FLASH, timer=0.
//   - flash_sync=0 at a tick while in FLASH: -> ALL_RED.
//  Outputs:
//   - Registered; they change on the same fast_clock edge as the state.
//   - walk_light=1 only in WALK.
//   - main=001 in WALK, SIDE_GRN, SIDE_YEL and ALL_RED.
//  walk_req:
//   - Set by walk_button=1 on any cycle, except while in WALK (ignored).
//   - Clear on WALK exit; clear wins over a simultaneous set.
//   - Entering FLASH does not clear walk_req; the request is served after recovery.
//  Invariant: never green or yellow on both roads; never walk with any green or yellow.
// TESTING (TICK_DIV=4, defaults otherwise)
//  1 reset mid-SIDE_GRN -> same cycle main=001, side=001, walk=0; first tick -> main=100.
//  2 no inputs -> main green 9 ticks, yellow 2, side green 6, yellow 2; period 19 ticks=76 clocks; led_clock period 8 clocks.
//  3 1-cycle walk_button at tick 1 of MAIN_GRN -> green ends after 6 ticks, yellow 2, then walk_light=1 for 3 ticks, then side=100; walk_pending falls as WALK exits.
//  4 side_sensor held high -> main green 6 ticks, side green 9 ticks; sensor drops at side timer=7 -> exit on the next tick.
//  5 flash_mode high during MAIN_YEL -> FLASH within 1 tick + 2 sync cycles, lamps alternate 001/000 per tick; release -> 2 ticks all-red, then main=100.
//  6 walk_button held through WALK -> exactly one walk phase, walk_pending=0 after WALK; every cycle checked against the invariant.

Source files
------------

// File: rtl/traffic_light_ctrl_if.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl_if
//   Signal bundle between a two-way junction controller and its surroundings
//   (push button, side-road loop sensor, maintenance switch, lamp drivers).
//
//   Requests into the controller:
//     walk_button   pedestrian request, any-width pulse
//     side_sensor   side-road vehicle present (level, asynchronous)
//     flash_mode    maintenance request (level, asynchronous)
//   Lamps and status out of the controller:
//     main[2:0]     main-street lamps  (100 green, 010 yellow, 001 red, 000 dark)
//     side[2:0]     side-street lamps  (same encoding)
//     walk_light    pedestrian walk lamp
//     led_clock     toggles once per phase tick (debug LED)
//     walk_pending  walk request latched, not yet served
//
//   master: the junction side (buttons and sensors drive, lamps are read).
//   slave : the controller.
// ----------------------------------------------------------------------------
interface traffic_light_ctrl_if;
    logic       walk_button;
    logic       side_sensor;
    logic       flash_mode;
    logic [2:0] main;
    logic [2:0] side;
    logic       walk_light;
    logic       led_clock;
    logic       walk_pending;

    modport master (
        output walk_button, side_sensor, flash_mode,
        input  main, side, walk_light, led_clock, walk_pending
    );

    modport slave (
        input  walk_button, side_sensor, flash_mode,
        output main, side, walk_light, led_clock, walk_pending
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// traffic_light_ctrl
//   Two-way (main/side) junction controller with a pedestrian phase, a
//   side-sensor-driven green shortening/extension and a flashing-red
//   maintenance mode. A built-in prescaler turns fast_clock into one-cycle
//   phase ticks, so everything runs in the single fast_clock domain.
//
//   Ports
//     fast_clock  in   system clock
//     reset       in   asynchronous, active-high
//     bus         slave side of traffic_light_ctrl_if:
//                   walk_button, side_sensor, flash_mode in;
//                   main, side, walk_light, led_clock, walk_pending out
//
//   Phase cycle: ALL_RED -> MAIN_GRN -> MAIN_YEL -> [WALK] -> SIDE_GRN
//                -> SIDE_YEL -> MAIN_GRN ...
//   flash_mode forces FLASH from any phase; leaving FLASH always passes
//   through an ALLRED_T-tick all-red clearance. The all-red phase entered
//   from reset lasts only until the first tick: the prescaler interval
//   that precedes that tick is the clearance.
// ----------------------------------------------------------------------------
module traffic_light_ctrl #(
    parameter int unsigned TICK_DIV    = 50_000_000,
    parameter int unsigned TW          = 5,
    parameter int unsigned MAIN_GRN    = 9,
    parameter int unsigned MAIN_GRN_SH = 6,
    parameter int unsigned SIDE_GRN    = 6,
    parameter int unsigned SIDE_GRN_LG = 9,
    parameter int unsigned YEL         = 2,
    parameter int unsigned WALK_T      = 3,
    parameter int unsigned ALLRED_T    = 2
) (
    input  logic                fast_clock,
    input  logic                reset,
    traffic_light_ctrl_if.slave bus
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    // Timer value on which each phase ends (duration - 1).
    localparam logic [TW-1:0] MAIN_GRN_LAST    = TW'(MAIN_GRN - 1);
    localparam logic [TW-1:0] MAIN_GRN_SH_LAST = TW'(MAIN_GRN_SH - 1);
    localparam logic [TW-1:0] SIDE_GRN_LAST    = TW'(SIDE_GRN - 1);
    localparam logic [TW-1:0] SIDE_GRN_LG_LAST = TW'(SIDE_GRN_LG - 1);
    localparam logic [TW-1:0] YEL_LAST         = TW'(YEL - 1);
    localparam logic [TW-1:0] WALK_LAST        = TW'(WALK_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST      = TW'(ALLRED_T - 1);

    localparam logic [2:0] LAMP_GRN  = 3'b100;
    localparam logic [2:0] LAMP_YEL  = 3'b010;
    localparam logic [2:0] LAMP_RED  = 3'b001;
    localparam logic [2:0] LAMP_DARK = 3'b000;

    typedef enum logic [2:0] {
        ST_ALL_RED,
        ST_MAIN_GRN,
        ST_MAIN_YEL,
        ST_WALK,
        ST_SIDE_GRN,
        ST_SIDE_YEL,
        ST_FLASH
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          led_q;
    logic          walk_req_q, walk_req_d;
    logic          walk_exit;
    logic          long_clear_q, long_clear_d;
    logic [1:0]    sensor_meta_q, flash_meta_q;
    logic          sensor_sync, flash_sync;
    logic [TW-1:0] phase_last;
    logic [2:0]    main_q, main_d;
    logic [2:0]    side_q, side_d;
    logic          walk_q, walk_d;

    // Lamp pattern for a phase. In FLASH the timer counts ticks since entry,
    // so its LSB selects red on even ticks and dark on odd ones.
    function automatic logic [6:0] decode_lamps(state_e st, logic odd_tick);
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        m = LAMP_RED;
        s = LAMP_RED;
        w = 1'b0;
        case (st)
            ST_MAIN_GRN: m = LAMP_GRN;
            ST_MAIN_YEL: m = LAMP_YEL;
            ST_WALK:     w = 1'b1;
            ST_SIDE_GRN: s = LAMP_GRN;
            ST_SIDE_YEL: s = LAMP_YEL;
            ST_FLASH: begin
                m = odd_tick ? LAMP_DARK : LAMP_RED;
                s = m;
            end
            default: ;
        endcase
        return {m, s, w};
    endfunction

    assign sensor_sync = sensor_meta_q[1];
    assign flash_sync  = flash_meta_q[1];

    assign tick    = (presc_q == PRESC_LAST);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    // Duration of the current phase, evaluated on every tick so that a
    // request arriving late in a green phase shortens it right away: once the
    // timer is already past the shorter limit, the >= compare below exits on
    // the very next tick.
    always_comb begin
        phase_last = '0;
        case (state_q)
            ST_ALL_RED:  phase_last = long_clear_q ? ALLRED_LAST : '0;
            ST_MAIN_GRN: phase_last = (walk_req_q || sensor_sync) ? MAIN_GRN_SH_LAST
                                                                  : MAIN_GRN_LAST;
            ST_MAIN_YEL: phase_last = YEL_LAST;
            ST_WALK:     phase_last = WALK_LAST;
            ST_SIDE_GRN: phase_last = sensor_sync ? SIDE_GRN_LG_LAST : SIDE_GRN_LAST;
            ST_SIDE_YEL: phase_last = YEL_LAST;
            default:     phase_last = '0;
        endcase
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        timer_d      = timer_q;
        long_clear_d = long_clear_q;
        if (tick) begin
            if (flash_sync && (state_q != ST_FLASH)) begin
                state_d = ST_FLASH;
                timer_d = '0;
            end else if (state_q == ST_FLASH) begin
                if (flash_sync) begin
                    timer_d = timer_q + 1'b1;
                end else begin
                    state_d      = ST_ALL_RED;
                    timer_d      = '0;
                    long_clear_d = 1'b1;
                end
            end else if (timer_q >= phase_last) begin
                timer_d = '0;
                case (state_q)
                    ST_ALL_RED: begin
                        state_d      = ST_MAIN_GRN;
                        long_clear_d = 1'b0;
                    end
                    ST_MAIN_GRN: state_d = ST_MAIN_YEL;
                    ST_MAIN_YEL: state_d = walk_req_q ? ST_WALK : ST_SIDE_GRN;
                    ST_WALK:     state_d = ST_SIDE_GRN;
                    ST_SIDE_GRN: state_d = ST_SIDE_YEL;
                    ST_SIDE_YEL: state_d = ST_MAIN_GRN;
                    default:     state_d = ST_ALL_RED;
                endcase
            end else begin
                timer_d = timer_q + 1'b1;
            end
        end
    end

    // Only a normal WALK -> SIDE_GRN exit serves the request; being pulled
    // into FLASH keeps it pending for after recovery.
    assign walk_exit = tick && (state_q == ST_WALK) && (state_d == ST_SIDE_GRN);

    always_comb begin
        walk_req_d = walk_req_q;
        if (walk_exit) begin
            walk_req_d = 1'b0;
        end else if (bus.walk_button && (state_q != ST_WALK)) begin
            walk_req_d = 1'b1;
        end
    end

    // Lamps are registered from the next state so they switch on the same
    // edge as the state itself.
    always_comb begin
        {main_d, side_d, walk_d} = decode_lamps(state_d, timer_d[0]);
    end

    always_ff @(posedge fast_clock or posedge reset) begin
        if (reset) begin
            presc_q       <= '0;
            led_q         <= 1'b0;
            sensor_meta_q <= '0;
            flash_meta_q  <= '0;
            state_q       <= ST_ALL_RED;
            timer_q       <= '0;
            walk_req_q    <= 1'b0;
            long_clear_q  <= 1'b0;
            main_q        <= LAMP_RED;
            side_q        <= LAMP_RED;
            walk_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples
            // the values from before this edge regardless of statement order.
            presc_q       <= presc_d;
            led_q         <= led_q ^ tick;
            sensor_meta_q <= {sensor_meta_q[0], bus.side_sensor};
            flash_meta_q  <= {flash_meta_q[0], bus.flash_mode};
            state_q       <= state_d;
            timer_q       <= timer_d;
            walk_req_q    <= walk_req_d;
            long_clear_q  <= long_clear_d;
            main_q        <= main_d;
            side_q        <= side_d;
            walk_q        <= walk_d;
        end
    end

    assign bus.main         = main_q;
    assign bus.side         = side_q;
    assign bus.walk_light   = walk_q;
    assign bus.led_clock    = led_q;
    assign bus.walk_pending = walk_req_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// ----------------------------------------------------------------------------
// tb_traffic_light_ctrl
//   Directed junction scenarios followed by a randomized stretch. A phase-level
//   reference model (phase name, ticks spent, phase-length table) predicts all
//   outputs every cycle; directed steps also measure phase lengths in clocks.
// ----------------------------------------------------------------------------
module tb_traffic_light_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int CPT         = TICK_DIV;   // clocks per tick
    localparam int MAIN_GRN    = 9;
    localparam int MAIN_GRN_SH = 6;
    localparam int SIDE_GRN    = 6;
    localparam int SIDE_GRN_LG = 9;
    localparam int YEL         = 2;
    localparam int WALK_T      = 3;
    localparam int ALLRED_T    = 2;

    localparam logic [2:0] LG = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LR = 3'b001;
    localparam logic [2:0] LD = 3'b000;

    localparam int W_MAIN    = 0;
    localparam int W_SIDE    = 1;
    localparam int W_WALK    = 2;
    localparam int W_LED     = 3;
    localparam int W_PENDING = 4;

    logic fast_clock = 1'b0;
    logic reset      = 1'b1;
    int   n_tests    = 0;
    int   n_fail     = 0;

    traffic_light_ctrl_if bus ();

    traffic_light_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .fast_clock (fast_clock),
        .reset      (reset),
        .bus        (bus)
    );

    always #5 fast_clock = ~fast_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {PH_CLEAR, PH_MAIN_GO, PH_MAIN_WARN, PH_PED,
                  PH_SIDE_GO, PH_SIDE_WARN, PH_MAINT} phase_t;

    phase_t   m_ph;
    int       m_spent;       // whole ticks already spent in m_ph
    bit       m_req;
    bit       m_long_clear;  // clearance after maintenance is ALLRED_T ticks
    bit       m_led;
    int       m_presc;
    bit [1:0] m_sens;        // [1] is the synchronised value
    bit [1:0] m_flash;

    function automatic int phase_len(phase_t ph, bit req, bit sens, bit long_clear);
        case (ph)
            PH_CLEAR:     return long_clear ? ALLRED_T : 1;
            PH_MAIN_GO:   return (req || sens) ? MAIN_GRN_SH : MAIN_GRN;
            PH_MAIN_WARN: return YEL;
            PH_PED:       return WALK_T;
            PH_SIDE_GO:   return sens ? SIDE_GRN_LG : SIDE_GRN;
            PH_SIDE_WARN: return YEL;
            default:      return 0;
        endcase
    endfunction

    function automatic phase_t successor(phase_t ph, bit req);
        case (ph)
            PH_CLEAR:     return PH_MAIN_GO;
            PH_MAIN_GO:   return PH_MAIN_WARN;
            PH_MAIN_WARN: return req ? PH_PED : PH_SIDE_GO;
            PH_PED:       return PH_SIDE_GO;
            PH_SIDE_GO:   return PH_SIDE_WARN;
            default:      return PH_MAIN_GO;
        endcase
    endfunction

    task automatic model_reset();
        m_ph = PH_CLEAR; m_spent = 0; m_req = 0; m_long_clear = 0;
        m_led = 0; m_presc = 0; m_sens = '0; m_flash = '0;
    endtask

    task automatic model_step();
        bit     tick    = (m_presc == TICK_DIV - 1);
        bit     req_old = m_req;
        phase_t ph_old  = m_ph;
        if (bus.walk_button && ph_old != PH_PED) m_req = 1;
        if (tick) begin
            if (m_flash[1] && ph_old != PH_MAINT) begin
                m_ph = PH_MAINT; m_spent = 0;
            end else if (ph_old == PH_MAINT) begin
                if (m_flash[1]) m_spent++;
                else begin m_ph = PH_CLEAR; m_spent = 0; m_long_clear = 1; end
            end else if (m_spent + 1 >= phase_len(ph_old, req_old, m_sens[1], m_long_clear)) begin
                if (ph_old == PH_PED) m_req = 0;
                if (ph_old == PH_CLEAR) m_long_clear = 0;
                m_ph = successor(ph_old, req_old);
                m_spent = 0;
            end else begin
                m_spent++;
            end
            m_led = ~m_led;
        end
        m_presc = tick ? 0 : m_presc + 1;
        m_sens  = {m_sens[0], bus.side_sensor};
        m_flash = {m_flash[0], bus.flash_mode};
    endtask

    function automatic logic [8:0] model_outputs();
        logic [2:0] m;
        logic [2:0] s;
        logic       w;
        m = LR; s = LR; w = 1'b0;
        case (m_ph)
            PH_MAIN_GO:   m = LG;
            PH_MAIN_WARN: m = LY;
            PH_PED:       w = 1'b1;
            PH_SIDE_GO:   s = LG;
            PH_SIDE_WARN: s = LY;
            PH_MAINT: begin m = (m_spent % 2 == 1) ? LD : LR; s = m; end
            default: ;
        endcase
        return {m, s, w, m_led, m_req};
    endfunction

    function automatic bit inv_ok(logic [2:0] m, logic [2:0] s, logic w);
        bit m_go;
        bit s_go;
        m_go = (m == LG) || (m == LY);
        s_go = (s == LG) || (s == LY);
        return !(m_go && s_go) && !(w && (m_go || s_go));
    endfunction

    always @(posedge fast_clock or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // Every cycle: full output vector against the model, plus the safety invariant.
    always @(negedge fast_clock) begin
        check("outputs", 32'({bus.main, bus.side, bus.walk_light, bus.led_clock, bus.walk_pending}),
              32'(model_outputs()));
        check("invariant", 32'(inv_ok(bus.main, bus.side, bus.walk_light)), 32'd1);
    end

    // ---------------- directed helpers ----------------
    function automatic logic [2:0] probe(int which);
        case (which)
            W_MAIN:    return bus.main;
            W_SIDE:    return bus.side;
            W_WALK:    return {2'b00, bus.walk_light};
            W_LED:     return {2'b00, bus.led_clock};
            default:   return {2'b00, bus.walk_pending};
        endcase
    endfunction

    // Counts negedges until the probed output shows v; a timeout is a failure.
    task automatic wait_val(input string tag, input int which, input logic [2:0] v,
                            input int limit, output int n);
        n = 0;
        while (probe(which) !== v && n < limit) begin
            @(negedge fast_clock);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < limit), 32'd1);
    endtask

    initial begin
        int n, n2, n3, n4;
        bus.walk_button = 1'b0;
        bus.side_sensor = 1'b0;
        bus.flash_mode  = 1'b0;

        // Power-on reset state.
        repeat (3) @(negedge fast_clock);
        check("reset_state", 32'({bus.main, bus.side, bus.walk_light, bus.led_clock, bus.walk_pending}),
              32'(9'b001_001_000));
        reset = 1'b0;

        // No inputs: 9 / 2 / 6 / 2 ticks, 76-clock period, 8-clock LED period.
        wait_val("first_green", W_MAIN, LG, 20, n);
        check("first_green_delay", n, CPT);
        wait_val("main_grn", W_MAIN, LY, 200, n);
        check("main_grn_len", n, MAIN_GRN * CPT);
        wait_val("main_yel", W_SIDE, LG, 50, n2);
        check("main_yel_len", n2, YEL * CPT);
        wait_val("side_grn", W_SIDE, LY, 200, n3);
        check("side_grn_len", n3, SIDE_GRN * CPT);
        wait_val("side_yel", W_MAIN, LG, 50, n4);
        check("side_yel_len", n4, YEL * CPT);
        check("period", n + n2 + n3 + n4, 76);
        wait_val("led_hi", W_LED, 3'd1, 20, n);
        wait_val("led_lo", W_LED, 3'd0, 20, n);
        wait_val("led_hi2", W_LED, 3'd1, 20, n2);
        check("led_period", n + n2, 8);

        // One-cycle walk press at tick 1 of main green.
        wait_val("s3_yel", W_MAIN, LY, 200, n);
        wait_val("s3_grn", W_MAIN, LG, 200, n);
        repeat (5) @(negedge fast_clock);
        bus.walk_button = 1'b1;
        @(negedge fast_clock);
        bus.walk_button = 1'b0;
        check("walk_latched", 32'(bus.walk_pending), 32'd1);
        wait_val("short_grn", W_MAIN, LY, 200, n);
        check("short_grn_len", 6 + n, MAIN_GRN_SH * CPT);
        wait_val("walk_on", W_WALK, 3'd1, 50, n);
        check("walk_delay", n, YEL * CPT);
        wait_val("walk_off", W_WALK, 3'd0, 50, n);
        check("walk_len", n, WALK_T * CPT);
        check("side_after_walk", 32'(bus.side), 32'(LG));
        check("pending_cleared", 32'(bus.walk_pending), 32'd0);

        // Side sensor held: main green 6 ticks; drop at side timer 7 -> 8 ticks.
        bus.side_sensor = 1'b1;
        wait_val("s4_grn", W_MAIN, LG, 200, n);
        wait_val("s4_main_grn", W_MAIN, LY, 200, n);
        check("sensor_main_grn_len", n, MAIN_GRN_SH * CPT);
        wait_val("s4_side_start", W_SIDE, LG, 50, n);
        repeat (29) @(negedge fast_clock);
        bus.side_sensor = 1'b0;
        wait_val("s4_side_grn", W_SIDE, LY, 100, n);
        check("late_drop_side_len", 29 + n, (7 + 1) * CPT);

        // Flash during main yellow; walk pressed while flashing is kept.
        wait_val("s5_grn", W_MAIN, LG, 200, n);
        wait_val("s5_yel", W_MAIN, LY, 200, n);
        bus.flash_mode = 1'b1;
        wait_val("flash_entry", W_MAIN, LR, 20, n);
        check("flash_entry_bound", 32'(n <= CPT + 2), 32'd1);
        check("flash_side_red", 32'(bus.side), 32'(LR));
        wait_val("flash_dark", W_MAIN, LD, 20, n);
        check("flash_dark_len", n, CPT);
        check("flash_side_dark", 32'(bus.side), 32'(LD));
        bus.walk_button = 1'b1;
        @(negedge fast_clock);
        bus.walk_button = 1'b0;
        check("walk_latched_in_flash", 32'(bus.walk_pending), 32'd1);
        wait_val("flash_red2", W_MAIN, LR, 20, n);
        check("flash_red2_len", n + 1, CPT);
        wait_val("flash_dark2", W_MAIN, LD, 20, n);
        check("flash_dark2_len", n, CPT);
        bus.flash_mode = 1'b0;
        wait_val("clear_entry", W_MAIN, LR, 20, n);
        check("clear_entry_delay", n, CPT);
        wait_val("clear_len", W_MAIN, LG, 40, n);
        check("clear_len", n, ALLRED_T * CPT);
        wait_val("s5_short", W_MAIN, LY, 200, n);
        check("recovered_short_grn", n, MAIN_GRN_SH * CPT);
        wait_val("s5_walk_on", W_WALK, 3'd1, 50, n);
        check("recovered_walk_delay", n, YEL * CPT);
        wait_val("s5_walk_off", W_WALK, 3'd0, 50, n);
        check("recovered_pending_clear", 32'(bus.walk_pending), 32'd0);

        // Button held through WALK: exactly one walk phase.
        wait_val("s6_grn", W_MAIN, LG, 200, n);
        bus.walk_button = 1'b1;
        wait_val("s6_walk_on", W_WALK, 3'd1, 200, n);
        wait_val("s6_walk_off", W_WALK, 3'd0, 50, n);
        check("held_pending_at_exit", 32'(bus.walk_pending), 32'd0);
        bus.walk_button = 1'b0;
        @(negedge fast_clock);
        check("held_pending_after", 32'(bus.walk_pending), 32'd0);
        wait_val("s6_next_grn", W_MAIN, LG, 200, n);
        wait_val("s6_next_yel", W_MAIN, LY, 200, n);
        check("no_second_walk_grn_len", n, MAIN_GRN * CPT);
        wait_val("s6_side", W_SIDE, LG, 50, n);
        check("no_second_walk_yel_len", n, YEL * CPT);

        // Asynchronous reset in the middle of side green.
        repeat (6) @(negedge fast_clock);
        #2 reset = 1'b1;
        #1;
        check("async_reset_lamps", 32'({bus.main, bus.side, bus.walk_light, bus.led_clock, bus.walk_pending}),
              32'(9'b001_001_000));
        @(negedge fast_clock);
        reset = 1'b0;
        wait_val("post_reset_grn", W_MAIN, LG, 20, n);
        check("post_reset_first_tick", n, CPT);

        // Randomized inputs against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge fast_clock);
            if ($urandom_range(0, 59) == 0) bus.side_sensor = ~bus.side_sensor;
            bus.walk_button = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 799) == 0) bus.flash_mode = ~bus.flash_mode;
        end
        bus.walk_button = 1'b0;
        bus.flash_mode  = 1'b0;
        repeat (20) @(negedge fast_clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
